// File: rtl/fuzz_dut_sequencer.sv
// fuzz_dut_sequencer
// Drives a synthesized fuzz DUT from a streamed vector source and compresses
// its sampled output into a 32-bit MISR signature.
//
// Run shape: an all-zero prime vector is sampled first. Each streamed vector
// is then loaded, held for SETTLE cycles and captured, until NUM_VEC+1
// samples have been folded into the signature.
//
// Optional feature (macro GOLDEN_CMP_EN): adds a golden_sig input and a
// registered mismatch output. The flag is evaluated when the run completes
// and cleared by the next start.
//
// Handshake (vec_valid / vec_ready): vec_ready is registered and is high only
// while the sequencer sits in LOAD. A vector transfers on any rising edge
// where vec_valid && vec_ready. vec_data need not be stable when vec_valid=0.
// The source may hold vec_valid low for as long as it likes, and the
// sequencer waits in LOAD with dut_in unchanged.

module fuzz_dut_sequencer #(
   parameter int          IN_W     = 57,
   parameter int          OUT_W    = 258,
   parameter int          NUM_VEC  = 20,
   parameter int          SETTLE   = 1,
   parameter logic [31:0] SIG_SEED = 32'hFFFFFFFF,
   parameter logic [31:0] POLY     = 32'h04C11DB7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [IN_W-1:0]   vec_data,
   output logic [IN_W-1:0]   dut_in,
   input  logic [OUT_W-1:0]  dut_y,
   output logic              busy,
   output logic              done,
   output logic [31:0]       signature,
   output logic [7:0]        smp_cnt
`ifdef GOLDEN_CMP_EN
   ,
   input  logic [31:0]       golden_sig,
   output logic              mismatch
`endif
);

   // Number of 32-bit slices that cover dut_y. The top slice is zero-padded.
   localparam int NSLICE = (OUT_W + 31) / 32;

   // Terminal values for the settle counter and the sample counter.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] LAST_SMP    = 8'(NUM_VEC);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRIME   = 3'd1,
      S_LOAD    = 3'd2,
      S_HOLD    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                  state;
   logic [7:0]              settle_cnt;
   logic [NSLICE*32-1:0]    y_pad;
   logic [31:0]             fold;
   logic [31:0]             sig_next;
   logic                    settle_last;
   logic                    abort_hit;

   // Fold the wide DUT output down to one 32-bit word by XOR of its slices.
   always_comb begin
      y_pad = '0;
      y_pad[OUT_W-1:0] = dut_y;
      fold = '0;
      for (int i = 0; i < NSLICE; i++) begin
         fold = fold ^ y_pad[i*32 +: 32];
      end
   end

   // One MISR step: shift, conditional polynomial feedback, then inject fold.
   assign sig_next = {signature[30:0], 1'b0}
                   ^ (signature[31] ? POLY : 32'h0)
                   ^ fold;

   // The settle counter has reached the end of the hold window.
   assign settle_last = (settle_cnt == SETTLE_LAST);

   // Abort only matters once a run is in flight; in IDLE it is a no-op.
   assign abort_hit = abort && (state != S_IDLE);

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         dut_in     <= '0;
         signature  <= '0;
         smp_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_ready  <= 1'b0;
`ifdef GOLDEN_CMP_EN
         mismatch   <= 1'b0;
`endif
      end else begin
         // done is a single-cycle pulse; it is raised only on entry to DONE.
         done <= 1'b0;

         if (abort_hit) begin
            // Abandon the run; signature and smp_cnt keep what they had.
            state     <= S_IDLE;
            dut_in    <= '0;
            busy      <= 1'b0;
            vec_ready <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  dut_in    <= '0;
                  vec_ready <= 1'b0;
                  // A start coinciding with abort is dropped as well.
                  if (start && !abort) begin
                     signature  <= SIG_SEED;
                     smp_cnt    <= '0;
                     settle_cnt <= '0;
                     busy       <= 1'b1;
                     state      <= S_PRIME;
`ifdef GOLDEN_CMP_EN
                     mismatch   <= 1'b0;
`endif
                  end
               end

               S_PRIME: begin
                  // The zero vector is already on dut_in from IDLE.
                  if (settle_last) begin
                     state <= S_CAPTURE;
                  end else begin
                     settle_cnt <= settle_cnt + 8'd1;
                  end
               end

               S_LOAD: begin
                  if (vec_valid && vec_ready) begin
                     dut_in     <= vec_data;
                     settle_cnt <= '0;
                     vec_ready  <= 1'b0;
                     state      <= S_HOLD;
                  end
               end

               S_HOLD: begin
                  if (settle_last) begin
                     state <= S_CAPTURE;
                  end else begin
                     settle_cnt <= settle_cnt + 8'd1;
                  end
               end

               S_CAPTURE: begin
                  signature <= sig_next;
                  smp_cnt   <= smp_cnt + 8'd1;
                  // smp_cnt still holds the pre-increment count here.
                  if (smp_cnt == LAST_SMP) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     vec_ready <= 1'b1;
                     state     <= S_LOAD;
                  end
               end

               S_DONE: begin
                  // Signature is frozen here, so its next value is itself.
                  busy   <= 1'b0;
                  dut_in <= '0;
                  state  <= S_IDLE;
`ifdef GOLDEN_CMP_EN
                  mismatch <= (signature != golden_sig);
`endif
               end

               default: begin
                  busy      <= 1'b0;
                  vec_ready <= 1'b0;
                  dut_in    <= '0;
                  state     <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fuzz_dut_sequencer.sv
// Testbench for fuzz_dut_sequencer.
// Randomized vectors and stalls; expected signatures come from a bit-level
// MISR model of the whole run (prime vector plus streamed vectors).
// Optional feature (macro GOLDEN_CMP_EN) is exercised when defined.

module tb_fuzz_dut_sequencer;

   localparam int          IN_W     = 57;
   localparam int          OUT_W    = 258;
   localparam int          NUM_VEC  = 3;
   localparam int          SETTLE   = 2;
   localparam logic [31:0] SIG_SEED = 32'hFFFFFFFF;
   localparam logic [31:0] POLY     = 32'h04C11DB7;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic              vec_valid;
   logic              vec_ready;
   logic [IN_W-1:0]   vec_data;
   logic [IN_W-1:0]   dut_in;
   logic [OUT_W-1:0]  dut_y;
   logic              busy;
   logic              done;
   logic [31:0]       signature;
   logic [7:0]        smp_cnt;
`ifdef GOLDEN_CMP_EN
   logic [31:0]       golden_sig;
   logic              mismatch;
`endif

   int checks;
   int errors;
   int cyc;
   int rdy_cnt;
   int done_cnt;
   int done_cyc;
   logic y_zero;
   logic [31:0] exp_q[$];

   fuzz_dut_sequencer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .SETTLE(SETTLE),
      .SIG_SEED(SIG_SEED), .POLY(POLY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
      .dut_in(dut_in), .dut_y(dut_y), .busy(busy), .done(done),
      .signature(signature), .smp_cnt(smp_cnt)
`ifdef GOLDEN_CMP_EN
      , .golden_sig(golden_sig), .mismatch(mismatch)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the fuzz DUT: a fixed scrambling of its inputs.
   function automatic logic [OUT_W-1:0] y_of(input logic [IN_W-1:0] v);
      logic [OUT_W-1:0] y;
      for (int j = 0; j < OUT_W; j++)
         y[j] = v[(j*13) % IN_W] ^ v[(j*5+1) % IN_W] ^ ((j % 3) == 0);
      return y;
   endfunction

   always_comb dut_y = y_zero ? '0 : y_of(dut_in);

   // Reference MISR step: bit j of y lands in fold bit j mod 32.
   function automatic logic [31:0] misr(input logic [31:0] s, input logic [OUT_W-1:0] y);
      logic [31:0] f;
      f = '0;
      for (int j = 0; j < OUT_W; j++) f[j % 32] = f[j % 32] ^ y[j];
      return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
   endfunction

   // Cycle monitor: counts cycles, vec_ready-high cycles and done pulses.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (vec_ready) rdy_cnt = rdy_cnt + 1;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int g;
      g = 0;
      while (!vec_ready && g < 100) begin
         step();
         g++;
      end
      if (g >= 100) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic rand_vec(output logic [IN_W-1:0] v);
      v = {$urandom(), $urandom()};
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   // Full run with random stalls in LOAD and stray starts while busy.
   task automatic run_once(input int max_stall);
      logic [IN_W-1:0] v;
      logic [IN_W-1:0] prev;
      logic [31:0] sig;
      int t0, r0, d0, st, stalls, g;
      y_zero = 1'b0;
      start = 1'b1;
      t0 = cyc; r0 = rdy_cnt; d0 = done_cnt;
      step();
      start = 1'b0;
      check("busy_rise", 64'(busy), 64'd1);
      sig = misr(SIG_SEED, y_of('0));
      stalls = 0;
      for (int i = 0; i < NUM_VEC; i++) begin
         wait_ready("load");
         prev = dut_in;
         st = $urandom_range(0, max_stall);
         for (int k = 0; k < st; k++) begin
            vec_valid = 1'b0;
            rand_vec(vec_data);
            start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            check("stall_hold", 64'(dut_in), 64'(prev));
            check("stall_rdy", 64'(vec_ready), 64'd1);
         end
         stalls += st;
         rand_vec(v);
         vec_valid = 1'b1;
         vec_data = v;
         step();
         vec_valid = 1'b0;
         check("vec_load", 64'(dut_in), 64'(v));
         sig = misr(sig, y_of(v));
      end
      exp_q.push_back(sig);
`ifdef GOLDEN_CMP_EN
      golden_sig = ($urandom_range(0, 1) == 1) ? sig : (sig ^ 32'h1);
`endif
      g = 0;
      while (done_cnt == d0 && g < 100) begin
         step();
         g++;
      end
      if (g >= 100) check("done_timeout", 64'd0, 64'd1);
      sig = exp_q.pop_front();
      check("run_len", 64'(done_cyc - t0),
            64'((SETTLE + 1) + NUM_VEC * (SETTLE + 2) + 1 + stalls));
      check("sig_done", 64'(signature), 64'(sig));
      check("smp_done", 64'(smp_cnt), 64'(NUM_VEC + 1));
      check("rdy_cycles", 64'(rdy_cnt - r0), 64'(NUM_VEC + stalls));
      step();
      check("done_pulse", 64'(done), 64'd0);
      check("busy_fall", 64'(busy), 64'd0);
      check("dut_in_idle", 64'(dut_in), 64'd0);
      check("sig_frozen", 64'(signature), 64'(sig));
`ifdef GOLDEN_CMP_EN
      check("mismatch", 64'(mismatch), 64'(sig != golden_sig));
`endif
      step();
      check("done_count", 64'(done_cnt - d0), 64'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] sig;
      int d0;
      checks = 0; errors = 0; cyc = 0; rdy_cnt = 0; done_cnt = 0; done_cyc = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
      vec_data = '0; y_zero = 1'b0;
`ifdef GOLDEN_CMP_EN
      golden_sig = '0;
`endif
      step(); step();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sig", 64'(signature), 64'd0);
      check("rst_smp", 64'(smp_cnt), 64'd0);
      check("rst_dut_in", 64'(dut_in), 64'd0);
      check("rst_ready", 64'(vec_ready), 64'd0);
      rst_n = 1'b1;
      step(); step();
      check("idle_busy", 64'(busy), 64'd0);

      // Prime sample with a zero DUT output, then stall in LOAD and abort.
      y_zero = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_ready("prime");
      check("prime_sig", 64'(signature), 64'h00000000FB3EE249);
      check("prime_smp", 64'(smp_cnt), 64'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("prime_stall_rdy", 64'(vec_ready), 64'd1);
         check("prime_stall_in", 64'(dut_in), 64'd0);
      end
      vec_valid = 1'b1;
      vec_data = 57'h0123456789ABCDE;
      step();
      vec_valid = 1'b0;
      check("fixed_load", 64'(dut_in), 64'h0123456789ABCDE);
      for (int k = 0; k < SETTLE; k++) begin
         step();
         check("fixed_hold", 64'(dut_in), 64'h0123456789ABCDE);
      end
      pulse_abort();
      check("abort0_busy", 64'(busy), 64'd0);
      y_zero = 1'b0;
      step();

      // Random full runs.
      run_once(0);
      run_once(0);
      for (int r = 0; r < 4; r++) run_once(3);

      // Abort in the second HOLD with a simultaneous start.
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      sig = misr(SIG_SEED, y_of('0));
      for (int i = 0; i < 2; i++) begin
         wait_ready("abort_load");
         rand_vec(vec_data);
         vec_valid = 1'b1;
         if (i == 0) sig = misr(sig, y_of(vec_data));
         step();
         vec_valid = 1'b0;
      end
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_dut_in", 64'(dut_in), 64'd0);
      check("abort_sig", 64'(signature), 64'(sig));
      check("abort_smp", 64'(smp_cnt), 64'd2);
      for (int k = 0; k < 10; k++) step();
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_idle", 64'(busy), 64'd0);
      check("abort_sig_kept", 64'(signature), 64'(sig));
      start = 1'b1;
      step();
      start = 1'b0;
      check("reseed_sig", 64'(signature), 64'(SIG_SEED));
      check("reseed_smp", 64'(smp_cnt), 64'd0);
      pulse_abort();

      // Asynchronous reset in the middle of HOLD.
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_ready("rst_load");
      vec_valid = 1'b1;
      vec_data = 57'h1ABC;
      step();
      vec_valid = 1'b0;
      check("rst_hold_in", 64'(dut_in), 64'h1ABC);
      rst_n = 1'b0;
      #1;
      check("arst_dut_in", 64'(dut_in), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_sig", 64'(signature), 64'd0);
      check("arst_smp", 64'(smp_cnt), 64'd0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("post_rst_busy", 64'(busy), 64'd0);
      end
      check("post_rst_in", 64'(dut_in), 64'd0);

      // One more full run after reset.
      run_once(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
